agc_cntr_inc_sched: RTL and testbench

//  Schedules counter-increment requests from NSRC external pulse sources (CDU/PIPA style) onto
//  the AGC counter-priority inputs, one transfer at a time. Accumulates a signed pending count
//  per source, picks sources round-robin, drives CAD cell address plus PCDU/MCDU, waits for the
//  AGC acknowledge. Sits between the external pulse models and the agc top in the sim harness.

---
 rtl/agc_cntr_inc_sched_pkg.sv | 15 +
 rtl/agc_cntr_inc_sched_if.sv | 21 ++
 rtl/agc_rr_arbiter.sv | 29 ++
 rtl/agc_cntr_inc_sched.sv | 141 ++++++++++++++
 tb/tb_agc_cntr_inc_sched.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/agc_cntr_inc_sched_pkg.sv
// Shared types and default constants for the AGC counter-increment scheduler.
// Also used by the sim harness for cell base and timing defaults.
package agc_cntr_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP
  } state_t;

  localparam logic [5:0] CELL_BASE_DEF = 6'o32;
  localparam int         GAP_DEF       = 2;
  localparam int         ACK_TMO_DEF   = 64;

endpackage

// File: rtl/agc_cntr_inc_sched_if.sv
// Counter-priority bus between the scheduler and the AGC counter logic.
// The scheduler is master: it drives cell address and strobes.
interface agc_cntr_inc_sched_if;

  logic [5:0] CAD;
  logic       PCDU;
  logic       MCDU;
  logic       inc_ack;
  logic       MGOJAM;

  modport master (
    output CAD, PCDU, MCDU,
    input  inc_ack, MGOJAM
  );

  modport slave (
    input  CAD, PCDU, MCDU,
    output inc_ack, MGOJAM
  );

endinterface

// File: rtl/agc_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr.
// Wraps around; valid low when no request is set.
module agc_rr_arbiter #(
  parameter int NSRC = 4,
  parameter int IW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [NSRC-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  always_comb begin : find
    int j;
    j     = 0;
    idx   = '0;
    valid = 1'b0;
    // Walk offsets high to low so the smallest offset wins.
    for (int k = NSRC - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NSRC) j = j - NSRC;
      if (req[j]) begin
        idx   = IW'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/agc_cntr_inc_sched.sv
// Schedules signed pending increments from NSRC pulse sources onto the
// AGC counter-priority bus, one transfer at a time, round-robin.
module agc_cntr_inc_sched
  import agc_cntr_pkg::*;
#(
  parameter int         NSRC      = 4,
  parameter int         CNT_W     = 8,
  parameter logic [5:0] CELL_BASE = CELL_BASE_DEF,
  parameter int         GAP       = GAP_DEF,
  parameter int         ACK_TMO   = ACK_TMO_DEF
) (
  input  logic                  SIM_CLK,
  input  logic                  SIM_RST_n,
  input  logic [NSRC-1:0]       src_up,
  input  logic [NSRC-1:0]       src_dn,
  agc_cntr_inc_sched_if.master  bus,
  output logic [NSRC-1:0]       pending,
  output logic [NSRC-1:0]       ovf,
  output logic                  tmo_err
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int SW = CNT_W + 2;
  localparam int TW = $clog2(ACK_TMO + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam logic signed [SW-1:0] ONE  = SW'(1);
  localparam logic signed [SW-1:0] LIM  = SW'(2 ** (CNT_W - 1) - 1);
  localparam logic signed [SW-1:0] NLIM = -LIM;

  logic [NSRC-1:0][CNT_W-1:0] cnt;
  logic [NSRC-1:0][CNT_W-1:0] cnt_nxt;
  logic [NSRC-1:0]            sat;
  logic [NSRC-1:0]            serve;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   ptr_nxt;
  logic [IW-1:0]   arb_idx;
  logic            arb_valid;
  logic            dir_neg;
  logic            ack_ev;
  logic [TW-1:0]   tmr;
  logic [GW-1:0]   gcnt;

  assign ack_ev  = (state == S_DRIVE) && bus.inc_ack && !bus.MGOJAM;
  assign ptr_nxt = (grant == IW'(NSRC - 1)) ? '0 : grant + 1'b1;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic signed [SW-1:0] sum;
    assign serve[i] = ack_ev && (grant == IW'(i));
    always_comb begin
      sum = SW'(signed'(cnt[i]));
      if (src_up[i]) sum = sum + ONE;
      if (src_dn[i]) sum = sum - ONE;
      if (serve[i])  sum = dir_neg ? sum + ONE : sum - ONE;
    end
    assign sat[i] = (sum > LIM) || (sum < NLIM);
    assign cnt_nxt[i] = (sum > LIM)  ? LIM[CNT_W-1:0]  :
                        (sum < NLIM) ? NLIM[CNT_W-1:0] :
                                       sum[CNT_W-1:0];
  end

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST_n) begin
      cnt     <= '0;
      pending <= '0;
      ovf     <= '0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf | sat;
      for (int k = 0; k < NSRC; k++)
        pending[k] <= |cnt_nxt[k];
    end
  end

  agc_rr_arbiter #(
    .NSRC (NSRC),
    .IW   (IW)
  ) u_arb (
    .req   (pending),
    .ptr   (ptr),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      grant    <= '0;
      dir_neg  <= 1'b0;
      tmr      <= '0;
      gcnt     <= '0;
      tmo_err  <= 1'b0;
      bus.CAD  <= '0;
      bus.PCDU <= 1'b0;
      bus.MCDU <= 1'b0;
    end else if (bus.MGOJAM) begin
      // Restart abandons the transfer and holds off grants.
      state    <= S_GAP;
      gcnt     <= '0;
      bus.CAD  <= '0;
      bus.PCDU <= 1'b0;
      bus.MCDU <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (arb_valid) begin
            grant    <= arb_idx;
            dir_neg  <= cnt[arb_idx][CNT_W-1];
            bus.CAD  <= CELL_BASE + 6'(arb_idx);
            bus.PCDU <= !cnt[arb_idx][CNT_W-1];
            bus.MCDU <= cnt[arb_idx][CNT_W-1];
            tmr      <= '0;
            state    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (bus.inc_ack || tmr == TW'(ACK_TMO - 1)) begin
            if (!bus.inc_ack) tmo_err <= 1'b1;
            ptr      <= ptr_nxt;
            gcnt     <= '0;
            bus.CAD  <= '0;
            bus.PCDU <= 1'b0;
            bus.MCDU <= 1'b0;
            state    <= S_GAP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_GAP: begin
          if (gcnt == GW'(GAP - 1)) state <= S_IDLE;
          else                      gcnt  <= gcnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_agc_cntr_inc_sched.sv
// Scoreboard bench for agc_cntr_inc_sched: integer reference model,
// directed scenarios followed by randomized pulse traffic.
`timescale 1ns/1ps
module tb_agc_cntr_inc_sched;

  localparam int NSRC    = 4;
  localparam int LIMIT   = 127;
  localparam int GAPC    = 2;
  localparam int TMO     = 64;
  localparam int BASE    = 26;

  typedef struct {
    int cad;
    bit neg;
  } xfer_t;

  logic            clk;
  logic            rst_n;
  logic [NSRC-1:0] src_up;
  logic [NSRC-1:0] src_dn;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] ovf;
  logic            tmo_err;

  agc_cntr_inc_sched_if bus ();

  agc_cntr_inc_sched dut (
    .SIM_CLK   (clk),
    .SIM_RST_n (rst_n),
    .src_up    (src_up),
    .src_dn    (src_dn),
    .bus       (bus),
    .pending   (pending),
    .ovf       (ovf),
    .tmo_err   (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model state
  int    m_cnt [NSRC];
  bit    m_ovf [NSRC];
  bit    m_busy, m_neg, m_tmo;
  int    m_g, m_ptr, m_cool, m_dcyc;
  xfer_t q [$];

  always @(posedge clk) begin : model
    bit ackev, tmoev, found, fneg;
    int fg, d, v, j;
    if (!rst_n) begin
      for (int i = 0; i < NSRC; i++) begin
        m_cnt[i] = 0;
        m_ovf[i] = 0;
      end
      m_busy = 0; m_neg = 0; m_tmo = 0;
      m_g = 0; m_ptr = 0; m_cool = 0; m_dcyc = 0;
    end else begin
      ackev = m_busy && bus.inc_ack && !bus.MGOJAM;
      tmoev = m_busy && !bus.inc_ack && !bus.MGOJAM
              && (m_dcyc == TMO - 1);
      found = 0; fg = 0; fneg = 0;
      for (int k = NSRC - 1; k >= 0; k--) begin
        j = (m_ptr + k) % NSRC;
        if (m_cnt[j] != 0) begin
          found = 1; fg = j; fneg = m_cnt[j] < 0;
        end
      end
      for (int i = 0; i < NSRC; i++) begin
        d = int'(src_up[i]) - int'(src_dn[i]);
        if (ackev && i == m_g) d = d + (m_neg ? 1 : -1);
        v = m_cnt[i] + d;
        if (v > LIMIT)  begin v = LIMIT;  m_ovf[i] = 1; end
        if (v < -LIMIT) begin v = -LIMIT; m_ovf[i] = 1; end
        m_cnt[i] = v;
      end
      if (bus.MGOJAM) begin
        m_busy = 0; m_cool = GAPC;
      end else if (ackev || tmoev) begin
        m_busy = 0; m_cool = GAPC;
        m_ptr = (m_g + 1) % NSRC;
        if (tmoev) m_tmo = 1;
      end else if (m_busy) begin
        m_dcyc++;
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (found) begin
        m_busy = 1; m_g = fg; m_neg = fneg; m_dcyc = 0;
        q.push_back('{cad: BASE + fg, neg: fneg});
      end
    end
  end

  // Monitor: per-cycle state checks and transfer scoreboard
  bit prev_strobe = 0;
  always @(negedge clk) begin : monitor
    int mp, mo;
    xfer_t x;
    mp = 0; mo = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (m_cnt[i] != 0) mp |= (1 << i);
      if (m_ovf[i])      mo |= (1 << i);
    end
    chk("both_strobes", int'(bus.PCDU && bus.MCDU), 0);
    chk("pcdu", int'(bus.PCDU), int'(m_busy && !m_neg));
    chk("mcdu", int'(bus.MCDU), int'(m_busy && m_neg));
    chk("cad", int'(bus.CAD), m_busy ? BASE + m_g : 0);
    chk("pending", int'(pending), mp);
    chk("ovf", int'(ovf), mo);
    chk("tmo_err", int'(tmo_err), int'(m_tmo));
    if ((bus.PCDU || bus.MCDU) && !prev_strobe) begin
      if (q.size() == 0) begin
        chk("xfer_unexpected", 1, 0);
      end else begin
        x = q.pop_front();
        chk("xfer_cad", int'(bus.CAD), x.cad);
        chk("xfer_dir", int'(bus.MCDU), int'(x.neg));
      end
    end
    prev_strobe = bus.PCDU || bus.MCDU;
  end

  // Ack responder
  bit ack_en = 1;
  bit spur   = 0;
  int ack_dly = 2;
  int wcnt = 0;
  always @(negedge clk) begin : responder
    if ((bus.PCDU || bus.MCDU) && ack_en) begin
      if (wcnt >= ack_dly) begin
        bus.inc_ack = 1'b1;
      end else begin
        bus.inc_ack = 1'b0;
        wcnt++;
      end
    end else begin
      wcnt = 0;
      bus.inc_ack = spur && ($urandom_range(0, 7) == 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [NSRC-1:0] up,
                       input logic [NSRC-1:0] dn);
    src_up = up; src_dn = dn;
    @(negedge clk);
    src_up = '0; src_dn = '0;
  endtask

  task automatic wait_strobe(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = bus.PCDU || bus.MCDU;
    end
    chk(name, int'(seen), 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = !m_busy;
      for (int k = 0; k < NSRC; k++)
        if (m_cnt[k] != 0) done = 0;
    end
    chk(name, int'(done), 1);
  endtask

  initial begin : stim
    bit hit;
    rst_n = 1'b0;
    src_up = '0; src_dn = '0;
    bus.MGOJAM = 1'b0;
    bus.inc_ack = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    #1;
    chk("rst_cad", int'(bus.CAD), 0);
    chk("rst_pending", int'(pending), 0);
    @(negedge clk);

    // T1: three up pulses on source 1
    ack_dly = 2;
    pulse(4'b0010, 4'b0000);
    pulse(4'b0010, 4'b0000);
    pulse(4'b0010, 4'b0000);
    wait_idle("t1_drain", 200);

    // T2: opposing counts on sources 0 and 2
    repeat (5) pulse(4'b0001, 4'b0100);
    wait_idle("t2_drain", 400);

    // T3: saturate source 3 with no acks
    ack_en = 0;
    repeat (130) pulse(4'b1000, 4'b0000);
    cyc(80);
    #1;
    chk("t3_ovf3", int'(ovf[3]), 1);
    chk("t3_tmo", int'(tmo_err), 1);
    @(negedge clk);
    ack_en = 1;
    ack_dly = 0;
    wait_idle("t3_drain", 3000);

    // T4: cancel, then dn pulses on the ack edge
    pulse(4'b0001, 4'b0001);
    cyc(4);
    ack_dly = 3;
    pulse(4'b0010, 4'b0000);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      #1;
      hit = bus.inc_ack;
    end
    chk("t4_ack_seen", int'(hit), 1);
    src_dn = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    src_dn = '0;
    wait_idle("t4_drain", 300);

    // T5: restart mid-transfer
    ack_en = 0;
    pulse(4'b0100, 4'b0000);
    wait_strobe("t5_strobe");
    cyc(2);
    bus.MGOJAM = 1'b1;
    cyc(3);
    bus.MGOJAM = 1'b0;
    ack_en = 1;
    wait_idle("t5_drain", 300);

    // T6: reset mid-transfer, then src0 served first
    ack_en = 0;
    pulse(4'b0100, 4'b0000);
    pulse(4'b0010, 4'b0000);
    wait_strobe("t6_strobe");
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("t6_strobes", int'(bus.PCDU || bus.MCDU), 0);
    chk("t6_cad", int'(bus.CAD), 0);
    chk("t6_pending", int'(pending), 0);
    chk("t6_tmo", int'(tmo_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1;
    ack_dly = 1;
    pulse(4'b1001, 4'b0000);
    wait_strobe("t6_first");
    chk("t6_first_cad", int'(bus.CAD), BASE);
    wait_idle("t6_drain", 300);

    // Randomized traffic
    spur = 1;
    for (int i = 0; i < 2500; i++) begin
      src_up = '0; src_dn = '0;
      for (int k = 0; k < NSRC; k++) begin
        src_up[k] = ($urandom_range(0, 7) == 0);
        src_dn[k] = ($urandom_range(0, 7) == 0);
      end
      bus.MGOJAM = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 31) == 0) ack_dly = $urandom_range(0, 4);
      @(negedge clk);
    end
    src_up = '0; src_dn = '0;
    bus.MGOJAM = 1'b0;
    spur = 0;
    ack_dly = 1;
    wait_idle("rand_drain", 3000);
    cyc(4);
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
